// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and sizing helpers for the sequential magnitude comparator.
// Optional feature macro used by this block: CMP_EARLY_EXIT_EN.
package cmp_pkg;

   // Controller states: wait for operands, walk the chunks, present the result
   typedef enum logic [1:0] {
      CMP_IDLE = 2'd0,
      CMP_SCAN = 2'd1,
      CMP_HOLD = 2'd2
   } cmp_state_t;

   // One-hot compare result; all zero while no result is being presented
   typedef struct packed {
      logic gt;
      logic lt;
      logic eq;
   } cmp_res_t;

   // Number of chunk steps needed to cover the operand
   function automatic int calc_n(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Width of the chunk index register, never narrower than one bit
   function automatic int calc_idx_w(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// Operand/result handshake bundle of the sequential magnitude comparator.
// master = operand producer / result consumer, slave = comparator.
interface seq_magnitude_comparator_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] porta;
   logic [WIDTH-1:0] portb;
   logic             is_signed;
   logic             out_valid;
   logic             out_ready;
   logic             equal;
   logic             less;
   logic             higher;

   modport master (
      output in_valid, porta, portb, is_signed, out_ready,
      input  in_ready, out_valid, equal, less, higher
   );

   modport slave (
      input  in_valid, porta, portb, is_signed, out_ready,
      output in_ready, out_valid, equal, less, higher
   );
endinterface

// File: rtl/seq_magnitude_comparator_chunk.sv
// Single CHUNK-bit unsigned comparator built from one subtract; the borrow
// out tells A < B, a zero difference tells A == B.
module chunk_compare #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output logic             lt,
   output logic             eq,
   output logic             gt
);
   logic [CHUNK:0] diff_s;

   // Extended subtract: bit CHUNK is the borrow out
   always_comb begin
      diff_s = {1'b0, a} - {1'b0, b};
      lt     = diff_s[CHUNK];
      eq     = (diff_s[CHUNK-1:0] == '0);
      gt     = ~diff_s[CHUNK] & (diff_s[CHUNK-1:0] != '0);
   end
endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: WIDTH-bit operands are compared CHUNK
// bits per cycle, most significant chunk first, through one shared chunk
// comparator. Signed mode resolves differing sign bits on the first chunk.
// Define CMP_EARLY_EXIT_EN to leave the scan on the first differing chunk;
// otherwise every transaction takes the full N-chunk scan.
module seq_magnitude_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic                      clk,
   input logic                      rst_n,
   seq_magnitude_comparator_if.slave bus
);
   localparam int             N       = calc_n(WIDTH, CHUNK);
   localparam int             IDX_W   = calc_idx_w(N);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);

   cmp_state_t       state_r;
   cmp_state_t       state_s;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             signed_r;
   logic [IDX_W-1:0] idx_r;
   logic             decided_r;
   logic             lt_r;
   logic             gt_r;
   logic             in_ready_r;
   logic             out_valid_r;
   cmp_res_t         res_r;

   logic [CHUNK-1:0] chunk_a_s;
   logic [CHUNK-1:0] chunk_b_s;
   logic             c_lt_s;
   logic             c_eq_s;
   logic             c_gt_s;
   logic             sign_diff_s;
   logic             step_lt_s;
   logic             step_gt_s;
   logic             step_dec_s;
   logic             scan_done_s;
   logic             accept_s;

   assign chunk_a_s = a_r[idx_r*CHUNK +: CHUNK];
   assign chunk_b_s = b_r[idx_r*CHUNK +: CHUNK];

   chunk_compare #(.CHUNK(CHUNK)) u_chunk (
      .a  (chunk_a_s),
      .b  (chunk_b_s),
      .lt (c_lt_s),
      .eq (c_eq_s),
      .gt (c_gt_s)
   );

   // Fold the current chunk into the running verdict; once decided, later chunks are ignored
   always_comb begin
      sign_diff_s = signed_r && (idx_r == IDX_MAX) && (a_r[WIDTH-1] != b_r[WIDTH-1]);
      step_lt_s   = lt_r;
      step_gt_s   = gt_r;
      step_dec_s  = decided_r;
      if (!decided_r) begin
         if (sign_diff_s) begin
            // negative A (sign bit set) is the smaller operand
            step_lt_s  = a_r[WIDTH-1];
            step_gt_s  = ~a_r[WIDTH-1];
            step_dec_s = 1'b1;
         end else begin
            step_lt_s  = c_lt_s;
            step_gt_s  = c_gt_s;
            step_dec_s = ~c_eq_s;
         end
      end else begin
         step_lt_s  = lt_r;
         step_gt_s  = gt_r;
         step_dec_s = 1'b1;
      end
`ifdef CMP_EARLY_EXIT_EN
      scan_done_s = (idx_r == '0) || step_dec_s;
`else
      scan_done_s = (idx_r == '0);
`endif
   end

   // Next-state logic of the IDLE -> SCAN -> HOLD -> IDLE controller
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      case (state_r)
         CMP_IDLE: begin
            if (bus.in_valid && in_ready_r) begin
               accept_s = 1'b1;
               state_s  = CMP_SCAN;
            end else begin
               state_s  = CMP_IDLE;
            end
         end
         CMP_SCAN: begin
            if (scan_done_s) begin
               state_s = CMP_HOLD;
            end else begin
               state_s = CMP_SCAN;
            end
         end
         CMP_HOLD: begin
            if (out_valid_r && bus.out_ready) begin
               state_s = CMP_IDLE;
            end else begin
               state_s = CMP_HOLD;
            end
         end
         default: begin
            state_s = CMP_IDLE;
         end
      endcase
   end

   // State, operand, scan and registered output updates
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= CMP_IDLE;
         a_r         <= '0;
         b_r         <= '0;
         signed_r    <= 1'b0;
         idx_r       <= IDX_MAX;
         decided_r   <= 1'b0;
         lt_r        <= 1'b0;
         gt_r        <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         res_r       <= '0;
      end else begin
         state_r    <= state_s;
         in_ready_r <= (state_s == CMP_IDLE);
         case (state_r)
            CMP_IDLE: begin
               if (accept_s) begin
                  a_r       <= bus.porta;
                  b_r       <= bus.portb;
                  signed_r  <= bus.is_signed;
                  idx_r     <= IDX_MAX;
                  decided_r <= 1'b0;
                  lt_r      <= 1'b0;
                  gt_r      <= 1'b0;
               end
            end
            CMP_SCAN: begin
               decided_r <= step_dec_s;
               lt_r      <= step_lt_s;
               gt_r      <= step_gt_s;
               if (scan_done_s) begin
                  out_valid_r <= 1'b1;
                  res_r       <= '{gt: step_gt_s, lt: step_lt_s, eq: ~step_dec_s};
               end else begin
                  idx_r <= idx_r - IDX_W'(1);
               end
            end
            CMP_HOLD: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  res_r       <= '0;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               res_r       <= '0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.equal     = res_r.eq;
   assign bus.less      = res_r.lt;
   assign bus.higher    = res_r.gt;

endmodule
